// File: rtl/spi_gain_bridge.sv
// ---------------------------------------------------------------------------
// spi_gain_bridge
//
// SPI mode-0 slave that lets an external host program the band-gain register
// map. Each 16-bit frame (MSB first) carries R/W in bit 15, a 7-bit address
// in bits 14:8 and a data byte in bits 7:0. Valid writes are turned into a
// single-cycle write strobe towards reg_map. A shadow copy of every gain code
// is kept so that read frames can return the current code on miso.
//
// All SPI pins are asynchronous to clk_i and pass through SYNC_STAGES-deep
// synchronizers. Every edge is detected on the synchronized copies.
//
// Parameters
//   NUM_BANDS    number of valid gain addresses (0..NUM_BANDS-1)
//   SYNC_STAGES  synchronizer depth on sclk/cs_n/mosi (>= 2)
//
// Ports
//   clk_i        system clock, at least 8x the sclk frequency
//   rst_i        asynchronous reset, active-high
//   sclk_i       SPI clock from the host
//   cs_n_i       SPI chip select, active-low
//   mosi_i       SPI data from the host, sampled on sclk rising edges
//   miso_o       SPI data to the host, updated on sclk falling edges
//   we_o         one-cycle write strobe to reg_map
//   addr_o       reg_map address, held until the next commit
//   data_in_o    reg_map gain code, held until the next commit
//   frame_err_o  one-cycle pulse when a frame is rejected
// ---------------------------------------------------------------------------
module spi_gain_bridge #(
  parameter int NUM_BANDS   = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       we_o,
  output logic [7:0] addr_o,
  output logic [7:0] data_in_o,
  output logic       frame_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    WAIT_CS
  } state_t;

  // Edge detection stays disabled until the synchronizers and the
  // previous-value registers hold real pin values; otherwise a cs_n pin that
  // is already low at reset release would look like a fresh falling edge.
  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int WARM_W   = $clog2(WARM_MAX + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic [WARM_W-1:0]      warm_q;

  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [15:0] rx_shift_q;
  logic [7:0]  tx_shift_q;
  logic        is_read_q;
  logic        over_q;
  logic        miso_q;
  logic        we_q;
  logic        frame_err_q;
  logic [7:0]  addr_q;
  logic [7:0]  data_q;
  logic [7:0]  shadow_q [NUM_BANDS];

  logic       sclk_s;
  logic       cs_s;
  logic       mosi_s;
  logic       edges_en;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs_rise;
  logic       cs_fall;
  logic [7:0] cmd_byte_d;
  logic [7:0] shadow_rd_d;
  logic [6:0] frm_addr_d;
  logic [7:0] frm_data_d;
  logic       frm_read_d;
  logic       frm_addr_ok_d;
  logic       frm_full_d;

  // Synchronizer chains, reset to the idle bus state (sclk low, cs_n high).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      warm_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      if (warm_q != WARM_MAX[WARM_W-1:0]) begin
        warm_q <= warm_q + 1'b1;
      end
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign edges_en  = (warm_q == WARM_MAX[WARM_W-1:0]);
  assign sclk_rise = edges_en &  sclk_s & ~sclk_prev_q;
  assign sclk_fall = edges_en & ~sclk_s &  sclk_prev_q;
  assign cs_rise   = edges_en &  cs_s   & ~cs_prev_q;
  assign cs_fall   = edges_en & ~cs_s   &  cs_prev_q;

  // The command byte as it will look once the current mosi bit is shifted in;
  // used on the 8th rising edge to preload the read data.
  assign cmd_byte_d = {rx_shift_q[6:0], mosi_s};

  // Shadow lookup for a read; addresses outside the band range read as zero.
  always_comb begin
    shadow_rd_d = 8'h00;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (cmd_byte_d[6:0] == 7'(i)) begin
        shadow_rd_d = shadow_q[i];
      end
    end
  end

  assign frm_read_d    = rx_shift_q[15];
  assign frm_addr_d    = rx_shift_q[14:8];
  assign frm_data_d    = rx_shift_q[7:0];
  assign frm_addr_ok_d = (int'(frm_addr_d) < NUM_BANDS);
  // A frame is complete only if exactly 16 bits arrived.
  assign frm_full_d    = (state_q == WAIT_CS) && !over_q;

  // Frame FSM with registered outputs. A cs_n rise has priority in every
  // state: it either commits the frame, flags it, or (in IDLE) is ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      is_read_q   <= 1'b0;
      over_q      <= 1'b0;
      miso_q      <= 1'b0;
      we_q        <= 1'b0;
      frame_err_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else begin
      we_q        <= 1'b0;
      frame_err_q <= 1'b0;

      if (cs_rise) begin
        state_q <= IDLE;
        miso_q  <= 1'b0;
        if (state_q != IDLE) begin
          if (frm_full_d && frm_read_d) begin
            // Complete read: nothing to commit.
          end else if (frm_full_d && frm_addr_ok_d) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
              if (frm_addr_d == 7'(i)) begin
                shadow_q[i] <= frm_data_d;
              end
            end
            addr_q <= {1'b0, frm_addr_d};
            data_q <= frm_data_d;
            we_q   <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
      end else begin
        case (state_q)
          IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall) begin
              state_q   <= CMD;
              bit_cnt_q <= '0;
              over_q    <= 1'b0;
              is_read_q <= 1'b0;
            end
          end

          CMD: begin
            if (sclk_rise) begin
              rx_shift_q <= {rx_shift_q[14:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == 4'd7) begin
                state_q    <= DATA;
                is_read_q  <= cmd_byte_d[7];
                tx_shift_q <= cmd_byte_d[7] ? shadow_rd_d : 8'h00;
              end
            end
          end

          DATA: begin
            if (sclk_rise) begin
              rx_shift_q <= {rx_shift_q[14:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == 4'd15) begin
                state_q <= WAIT_CS;
              end
            end else if (sclk_fall && is_read_q) begin
              miso_q     <= tx_shift_q[7];
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end
          end

          WAIT_CS: begin
            if (sclk_rise) begin
              over_q <= 1'b1;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign miso_o      = miso_q;
  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign data_in_o   = data_q;
  assign frame_err_o = frame_err_q;

endmodule
